// File: rtl/ex_stage_alu.sv
// Execute stage: operand forwarding, ALU and the EX/MEM pipeline register.
// Undefined ALU codes on valid slots suppress all architectural side effects.
module ex_stage_alu #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [3:0]        alu_ctl,
  input  logic              alu_src,
  input  logic [WIDTH-1:0]  rs_data,
  input  logic [WIDTH-1:0]  rt_data,
  input  logic [WIDTH-1:0]  imm,
  input  logic [1:0]        fwd_a,
  input  logic [1:0]        fwd_b,
  input  logic [WIDTH-1:0]  exmem_data,
  input  logic [WIDTH-1:0]  memwb_data,
  input  logic [REG_AW-1:0] rd_in,
  input  logic              reg_write_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic              stall,
  input  logic              flush,
  output logic              out_valid,
  output logic [WIDTH-1:0]  alu_result,
  output logic              zero,
  output logic [WIDTH-1:0]  store_data,
  output logic [REG_AW-1:0] rd_out,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              illegal_op
);

  // Returns {undefined, result}; undefined codes yield a zero result.
  function automatic logic [WIDTH:0] alu_op(input logic [3:0] ctl,
                                            input logic [WIDTH-1:0] a,
                                            input logic [WIDTH-1:0] b);
    logic [WIDTH:0] r;
    case (ctl)
      4'b0000: r = {1'b0, a & b};
      4'b0001: r = {1'b0, a | b};
      4'b0010: r = {1'b0, a + b};
      4'b0110: r = {1'b0, a - b};
      4'b0111: r = {1'b0, {(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      4'b1100: r = {1'b0, ~(a | b)};
      default: r = {1'b1, {WIDTH{1'b0}}};
    endcase
    return r;
  endfunction

  logic [WIDTH-1:0]  op_a_s, op_bf_s, op_b_s, result_s;
  logic              undef_s;

  logic              out_valid_r, zero_r, reg_write_r, mem_read_r, mem_write_r, illegal_op_r;
  logic [WIDTH-1:0]  alu_result_r, store_data_r;
  logic [REG_AW-1:0] rd_out_r;

  // Forwarding muxes, immediate select and ALU evaluation.
  always_comb begin
    op_a_s  = rs_data;
    op_bf_s = rt_data;
    case (fwd_a)
      2'b01:   op_a_s = memwb_data;
      2'b10:   op_a_s = exmem_data;
      default: op_a_s = rs_data;
    endcase
    case (fwd_b)
      2'b01:   op_bf_s = memwb_data;
      2'b10:   op_bf_s = exmem_data;
      default: op_bf_s = rt_data;
    endcase
    if (alu_src) begin
      op_b_s = imm;
    end else begin
      op_b_s = op_bf_s;
    end
    {undef_s, result_s} = alu_op(alu_ctl, op_a_s, op_b_s);
  end

  // EX/MEM register: reset, then flush, then stall hold, then load.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      out_valid_r  <= 1'b0;
      alu_result_r <= {WIDTH{1'b0}};
      zero_r       <= 1'b0;
      store_data_r <= {WIDTH{1'b0}};
      rd_out_r     <= {REG_AW{1'b0}};
      reg_write_r  <= 1'b0;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      illegal_op_r <= 1'b0;
    end else if (!stall) begin
      out_valid_r  <= in_valid;
      alu_result_r <= result_s;
      zero_r       <= (result_s == {WIDTH{1'b0}});
      store_data_r <= op_bf_s;
      rd_out_r     <= rd_in;
      // Side-effect bits only pass for real, decodable instructions.
      reg_write_r  <= in_valid & ~undef_s & reg_write_in;
      mem_read_r   <= in_valid & ~undef_s & mem_read_in;
      mem_write_r  <= in_valid & ~undef_s & mem_write_in;
      illegal_op_r <= in_valid & undef_s;
    end
  end

  assign out_valid  = out_valid_r;
  assign alu_result = alu_result_r;
  assign zero       = zero_r;
  assign store_data = store_data_r;
  assign rd_out     = rd_out_r;
  assign reg_write  = reg_write_r;
  assign mem_read   = mem_read_r;
  assign mem_write  = mem_write_r;
  assign illegal_op = illegal_op_r;

endmodule

// File: tb/tb_ex_stage_alu.sv
// Scoreboard bench for ex_stage_alu: the driver queues hand-computed EX/MEM
// contents after each edge; an independent monitor compares them.
module tb_ex_stage_alu;

  logic        clk = 1'b0;
  logic        reset, in_valid, alu_src, reg_write_in, mem_read_in, mem_write_in, stall, flush;
  logic [3:0]  alu_ctl;
  logic [31:0] rs_data, rt_data, imm, exmem_data, memwb_data;
  logic [1:0]  fwd_a, fwd_b;
  logic [4:0]  rd_in;
  logic        out_valid, zero, reg_write, mem_read, mem_write, illegal_op;
  logic [31:0] alu_result, store_data;
  logic [4:0]  rd_out;

  typedef struct packed {
    logic        v;
    logic [31:0] res;
    logic        z;
    logic [31:0] st;
    logic [4:0]  rd;
    logic        rw, mr, mw, il;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  ex_stage_alu #(.WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_ctl(alu_ctl), .alu_src(alu_src),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .exmem_data(exmem_data), .memwb_data(memwb_data), .rd_in(rd_in),
    .reg_write_in(reg_write_in), .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
    .stall(stall), .flush(flush), .out_valid(out_valid), .alu_result(alu_result),
    .zero(zero), .store_data(store_data), .rd_out(rd_out), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .illegal_op(illegal_op)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic v, input logic [31:0] res, input logic z,
                              input logic [31:0] st, input logic [4:0] rd,
                              input logic rw, input logic mr, input logic mw, input logic il);
    exp_t e;
    e.v = v; e.res = res; e.z = z; e.st = st; e.rd = rd;
    e.rw = rw; e.mr = mr; e.mw = mw; e.il = il;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Inputs change on the falling edge; the expected register contents are queued after the rising edge.
  task automatic step(input logic rst, input logic v, input logic [3:0] ctl, input logic src,
                      input logic [31:0] rs, input logic [31:0] rt, input logic [31:0] im,
                      input logic [1:0] fa, input logic [1:0] fb,
                      input logic [31:0] ex, input logic [31:0] wb, input logic [4:0] rd,
                      input logic rwi, input logic mri, input logic mwi,
                      input logic st, input logic fl, input exp_t e);
    @(negedge clk);
    reset = rst; in_valid = v; alu_ctl = ctl; alu_src = src; rs_data = rs; rt_data = rt;
    imm = im; fwd_a = fa; fwd_b = fb; exmem_data = ex; memwb_data = wb; rd_in = rd;
    reg_write_in = rwi; mem_read_in = mri; mem_write_in = mwi; stall = st; flush = fl;
    @(posedge clk);
    exp_q.push_back(e);
  endtask

  // Monitor: compares every queued expectation against the registered outputs.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("out_valid",  {31'd0, out_valid},  {31'd0, e.v});
        check("alu_result", alu_result,          e.res);
        check("zero",       {31'd0, zero},       {31'd0, e.z});
        check("store_data", store_data,          e.st);
        check("rd_out",     {27'd0, rd_out},     {27'd0, e.rd});
        check("reg_write",  {31'd0, reg_write},  {31'd0, e.rw});
        check("mem_read",   {31'd0, mem_read},   {31'd0, e.mr});
        check("mem_write",  {31'd0, mem_write},  {31'd0, e.mw});
        check("illegal_op", {31'd0, illegal_op}, {31'd0, e.il});
      end
    end
  end

  initial begin
    exp_t zr, h;
    int waited;
    zr = mk(1'b0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    // Reset with random inputs, including stall and flush lines.
    repeat (2)
      step(1'b1, 1'($urandom), 4'($urandom), 1'($urandom), $urandom, $urandom, $urandom,
           2'($urandom), 2'($urandom), $urandom, $urandom, 5'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), zr);
    // Add wraps to zero.
    step(1'b0, 1'b1, 4'b0010, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd3,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 32'd0, 1'b1, 32'd1, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0));
    // Signed less-than, both orders.
    step(1'b0, 1'b1, 4'b0111, 1'b0, 32'h8000_0000, 32'd1, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd4,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 32'd1, 1'b0, 32'd1, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b1, 4'b0111, 1'b0, 32'd1, 32'h8000_0000, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd5,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'd0, 1'b1, 32'h8000_0000, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0));
    // Forwarding into subtract, then immediate on B with store_data still forwarded.
    step(1'b0, 1'b1, 4'b0110, 1'b0, 32'd100, 32'd200, 32'd5, 2'b10, 2'b01, 32'd7, 32'd3, 5'd6,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b1, 32'd4, 1'b0, 32'd3, 5'd6, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b1, 4'b0110, 1'b1, 32'd100, 32'd200, 32'd5, 2'b10, 2'b01, 32'd7, 32'd3, 5'd6,
         1'b0, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b1, 32'd2, 1'b0, 32'd3, 5'd6, 1'b0, 1'b0, 1'b1, 1'b0));
    // AND with fwd 11 = rs and fwd_b from EX/MEM; OR as a load; NOR of zeros.
    step(1'b0, 1'b1, 4'b0000, 1'b0, 32'h0000_F0F0, 32'd9, 32'd0, 2'b11, 2'b10, 32'h0000_0FF0, 32'd0,
         5'd8, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h0000_00F0, 1'b0, 32'h0000_0FF0, 5'd8, 1'b1, 1'b0, 1'b0, 1'b0));
    step(1'b0, 1'b1, 4'b0001, 1'b1, 32'h0000_00F0, 32'd1, 32'h0000_000F, 2'b00, 2'b00, 32'd0, 32'd0,
         5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'h0000_00FF, 1'b0, 32'd1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0));
    step(1'b0, 1'b1, 4'b1100, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd10,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
         mk(1'b1, 32'hFFFF_FFFF, 1'b0, 32'd0, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0));
    // Load 4+5, hold through three stalls with changing inputs, then flush beats stall.
    h = mk(1'b1, 32'd9, 1'b0, 32'd5, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0010, 1'b0, 32'd4, 32'd5, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd7,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, h);
    for (int i = 0; i < 3; i++)
      step(1'b0, 1'b1, 4'b0110, 1'b1, 32'd50 + i, 32'd1, 32'd2, 2'b00, 2'b00, 32'd0, 32'd0, 5'd12,
           1'b0, 1'b1, 1'b1, 1'b1, 1'b0, h);
    step(1'b0, 1'b1, 4'b0010, 1'b0, 32'd4, 32'd5, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd7,
         1'b1, 1'b0, 1'b0, 1'b1, 1'b1, zr);
    // Undefined code on a valid slot, then on an empty slot.
    step(1'b0, 1'b1, 4'b1111, 1'b0, 32'd5, 32'd6, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd11,
         1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b1, 32'd0, 1'b1, 32'd6, 5'd11, 1'b0, 1'b0, 1'b0, 1'b1));
    step(1'b0, 1'b0, 4'b1111, 1'b0, 32'd5, 32'd6, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd11,
         1'b1, 1'b0, 1'b1, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b1, 32'd6, 5'd11, 1'b0, 1'b0, 1'b0, 1'b0));
    // Empty slot with a legal op: data loads, controls stay off.
    step(1'b0, 1'b0, 4'b0010, 1'b0, 32'd2, 32'd3, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd13,
         1'b1, 1'b1, 1'b1, 1'b0, 1'b0, mk(1'b0, 32'd5, 1'b0, 32'd3, 5'd13, 1'b0, 1'b0, 1'b0, 1'b0));
    // Reset in the middle of a stall, then release with an empty slot.
    h = mk(1'b1, 32'd3, 1'b0, 32'd2, 5'd14, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 4'b0010, 1'b0, 32'd1, 32'd2, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd14,
         1'b1, 1'b0, 1'b0, 1'b0, 1'b0, h);
    step(1'b0, 1'b1, 4'b0000, 1'b0, 32'd7, 32'd7, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd15,
         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, h);
    step(1'b1, 1'b1, 4'b0000, 1'b0, 32'd7, 32'd7, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd15,
         1'b1, 1'b0, 1'b0, 1'b1, 1'b0, zr);
    step(1'b0, 1'b0, 4'b0001, 1'b0, 32'd0, 32'd0, 32'd0, 2'b00, 2'b00, 32'd0, 32'd0, 5'd0,
         1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mk(1'b0, 32'd0, 1'b1, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    // Drain the scoreboard within a bounded number of cycles.
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(posedge clk);
      waited++;
    end
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
